// File: rtl/operand_skew_feeder_if.sv
// Write, load and operand-output bundle between the operand source, the load/start
// sequencer and the MAC array edge.
interface operand_skew_feeder_if #(
   parameter int N      = 2,
   parameter int M      = 2,
   parameter int DATA_W = 8
);
   localparam int AL_W = (N > 1) ? $clog2(N) : 1;
   localparam int BL_W = (M > 1) ? $clog2(M) : 1;

   logic                a_wr_en;
   logic [AL_W-1:0]     a_wr_lane;
   logic [DATA_W-1:0]   a_wr_data;
   logic                b_wr_en;
   logic [BL_W-1:0]     b_wr_lane;
   logic [DATA_W-1:0]   b_wr_data;
   logic                load;
   logic [N-1:0]        A_start_en;
   logic [M-1:0]        B_start_en;
   logic [N*DATA_W-1:0] A_out;
   logic [N-1:0]        A_valid;
   logic [M*DATA_W-1:0] B_out;
   logic [M-1:0]        B_valid;
   logic [N-1:0]        a_full;
   logic [M-1:0]        b_full;
   logic                finished;
   logic                err;

   modport master (
      output a_wr_en, a_wr_lane, a_wr_data, b_wr_en, b_wr_lane, b_wr_data,
             load, A_start_en, B_start_en,
      input  A_out, A_valid, B_out, B_valid, a_full, b_full, finished, err
   );

   modport slave (
      input  a_wr_en, a_wr_lane, a_wr_data, b_wr_en, b_wr_lane, b_wr_data,
             load, A_start_en, B_start_en,
      output A_out, A_valid, B_out, B_valid, a_full, b_full, finished, err
   );
endinterface

// File: rtl/operand_skew_feeder.sv
// Per-lane circular operand FIFOs for the systolic array edge; one registered pop per
// enabled lane on each load pulse, with a finished flag once all lanes drain.
module operand_skew_feeder #(
   parameter int N      = 2,
   parameter int M      = 2,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   operand_skew_feeder_if.slave bus
);
   localparam int AL_W  = (N > 1) ? $clog2(N) : 1;
   localparam int BL_W  = (M > 1) ? $clog2(M) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0]   a_mem_q [N][DEPTH];
   logic [DATA_W-1:0]   a_mem_d [N][DEPTH];
   logic [PTR_W-1:0]    a_rd_ptr_q [N];
   logic [PTR_W-1:0]    a_rd_ptr_d [N];
   logic [PTR_W-1:0]    a_wr_ptr_q [N];
   logic [PTR_W-1:0]    a_wr_ptr_d [N];
   logic [CNT_W-1:0]    a_cnt_q [N];
   logic [CNT_W-1:0]    a_cnt_d [N];
   logic [N*DATA_W-1:0] a_out_q, a_out_d;
   logic [N-1:0]        a_valid_q, a_valid_d;
   logic [N-1:0]        a_pop, a_wr_hit, a_full;

   logic [DATA_W-1:0]   b_mem_q [M][DEPTH];
   logic [DATA_W-1:0]   b_mem_d [M][DEPTH];
   logic [PTR_W-1:0]    b_rd_ptr_q [M];
   logic [PTR_W-1:0]    b_rd_ptr_d [M];
   logic [PTR_W-1:0]    b_wr_ptr_q [M];
   logic [PTR_W-1:0]    b_wr_ptr_d [M];
   logic [CNT_W-1:0]    b_cnt_q [M];
   logic [CNT_W-1:0]    b_cnt_d [M];
   logic [M*DATA_W-1:0] b_out_q, b_out_d;
   logic [M-1:0]        b_valid_q, b_valid_d;
   logic [M-1:0]        b_pop, b_wr_hit, b_full;

   logic armed_q, armed_d;
   logic finished_q, finished_d;
   logic err_q, err_d;
   logic a_acc, b_acc, all_empty;

   // A side. Out-of-range lane indices never match a lane, so they are simply not accepted.
   always_comb begin
      a_mem_d    = a_mem_q;
      a_rd_ptr_d = a_rd_ptr_q;
      a_wr_ptr_d = a_wr_ptr_q;
      a_cnt_d    = a_cnt_q;
      a_out_d    = a_out_q;
      a_valid_d  = '0;
      a_pop      = '0;
      a_wr_hit   = '0;
      a_full     = '0;
      for (int i = 0; i < N; i++) begin
         a_full[i]   = (a_cnt_q[i] == CNT_W'(DEPTH));
         a_pop[i]    = bus.load && bus.A_start_en[i] && (a_cnt_q[i] != '0);
         a_wr_hit[i] = bus.a_wr_en && (bus.a_wr_lane == AL_W'(i)) && (!a_full[i] || a_pop[i]);
         if (a_pop[i]) begin
            a_out_d[i*DATA_W +: DATA_W] = a_mem_q[i][a_rd_ptr_q[i]];
            a_valid_d[i]  = 1'b1;
            a_rd_ptr_d[i] = a_rd_ptr_q[i] + PTR_W'(1);
         end else if (bus.load) begin
            a_out_d[i*DATA_W +: DATA_W] = '0;
         end
         if (a_wr_hit[i]) begin
            a_mem_d[i][a_wr_ptr_q[i]] = bus.a_wr_data;
            a_wr_ptr_d[i] = a_wr_ptr_q[i] + PTR_W'(1);
         end
         a_cnt_d[i] = a_cnt_q[i] + CNT_W'(a_wr_hit[i]) - CNT_W'(a_pop[i]);
      end
      a_acc = |a_wr_hit;
   end

   always_comb begin
      b_mem_d    = b_mem_q;
      b_rd_ptr_d = b_rd_ptr_q;
      b_wr_ptr_d = b_wr_ptr_q;
      b_cnt_d    = b_cnt_q;
      b_out_d    = b_out_q;
      b_valid_d  = '0;
      b_pop      = '0;
      b_wr_hit   = '0;
      b_full     = '0;
      for (int j = 0; j < M; j++) begin
         b_full[j]   = (b_cnt_q[j] == CNT_W'(DEPTH));
         b_pop[j]    = bus.load && bus.B_start_en[j] && (b_cnt_q[j] != '0);
         b_wr_hit[j] = bus.b_wr_en && (bus.b_wr_lane == BL_W'(j)) && (!b_full[j] || b_pop[j]);
         if (b_pop[j]) begin
            b_out_d[j*DATA_W +: DATA_W] = b_mem_q[j][b_rd_ptr_q[j]];
            b_valid_d[j]  = 1'b1;
            b_rd_ptr_d[j] = b_rd_ptr_q[j] + PTR_W'(1);
         end else if (bus.load) begin
            b_out_d[j*DATA_W +: DATA_W] = '0;
         end
         if (b_wr_hit[j]) begin
            b_mem_d[j][b_wr_ptr_q[j]] = bus.b_wr_data;
            b_wr_ptr_d[j] = b_wr_ptr_q[j] + PTR_W'(1);
         end
         b_cnt_d[j] = b_cnt_q[j] + CNT_W'(b_wr_hit[j]) - CNT_W'(b_pop[j]);
      end
      b_acc = |b_wr_hit;
   end

   // finished looks at post-update counts so it rises in the cycle after the last pop.
   always_comb begin
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) if (a_cnt_d[i] != '0) all_empty = 1'b0;
      for (int j = 0; j < M; j++) if (b_cnt_d[j] != '0) all_empty = 1'b0;
      armed_d    = armed_q | a_acc | b_acc;
      err_d      = err_q | (bus.a_wr_en & ~a_acc) | (bus.b_wr_en & ~b_acc);
      finished_d = armed_d & all_empty & ~a_acc & ~b_acc;
   end

   always_ff @(posedge clk) begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      if (rst) begin
         a_rd_ptr_q <= '{default: '0};
         a_wr_ptr_q <= '{default: '0};
         a_cnt_q    <= '{default: '0};
         a_out_q    <= '0;
         a_valid_q  <= '0;
         b_rd_ptr_q <= '{default: '0};
         b_wr_ptr_q <= '{default: '0};
         b_cnt_q    <= '{default: '0};
         b_out_q    <= '0;
         b_valid_q  <= '0;
         armed_q    <= 1'b0;
         finished_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         a_rd_ptr_q <= a_rd_ptr_d;
         a_wr_ptr_q <= a_wr_ptr_d;
         a_cnt_q    <= a_cnt_d;
         a_out_q    <= a_out_d;
         a_valid_q  <= a_valid_d;
         b_rd_ptr_q <= b_rd_ptr_d;
         b_wr_ptr_q <= b_wr_ptr_d;
         b_cnt_q    <= b_cnt_d;
         b_out_q    <= b_out_d;
         b_valid_q  <= b_valid_d;
         armed_q    <= armed_d;
         finished_q <= finished_d;
         err_q      <= err_d;
      end
   end

   assign bus.A_out    = a_out_q;
   assign bus.A_valid  = a_valid_q;
   assign bus.B_out    = b_out_q;
   assign bus.B_valid  = b_valid_q;
   assign bus.a_full   = a_full;
   assign bus.b_full   = b_full;
   assign bus.finished = finished_q;
   assign bus.err      = err_q;
endmodule
